asrv32_alu_mdu: RTL

//  Parametrised execute unit: base RV32I ALU ops plus RV32M multiply/divide, with valid/ready handshake.

---
 rtl/asrv32_alu_mdu.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/asrv32_alu_mdu.sv
// Execute unit: one-hot RV32I ALU ops plus RV32M multiply/divide behind a valid/ready handshake.
// Base ops and MUL (MUL_LATENCY=1) finish in one cycle; DIV/REM run a 1-bit/cycle restoring divider.
module asrv32_alu_mdu #(
    parameter int XLEN        = 32,
    parameter int MUL_LATENCY = 1,
    parameter int ALU_WIDTH   = 14
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [ALU_WIDTH-1:0] i_alu,
    input  logic                 i_mdu_en,
    input  logic [2:0]           i_funct3,
    input  logic [XLEN-1:0]      i_op1,
    input  logic [XLEN-1:0]      i_op2,
    input  logic                 i_flush,
    output logic                 o_valid,
    output logic [XLEN-1:0]      o_result
);
    localparam int A_ADD = 0, A_SUB = 1, A_SLT = 2, A_SLTU = 3, A_XOR = 4, A_OR = 5, A_AND = 6;
    localparam int A_SLL = 7, A_SRL = 8, A_SRA = 9, A_EQ = 10, A_NEQ = 11, A_GE = 12, A_GEU = 13;
    localparam int SHW = $clog2(XLEN);
    localparam int CW  = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] SMIN = XLEN'(1) << (XLEN - 1);

    typedef enum logic [1:0] {IDLE, MUL2, DIV, FIX} state_t;
    state_t state;

    assign o_ready = (state == IDLE);

    logic [XLEN-1:0] alu_res;
    logic [SHW-1:0]  shamt;
    assign shamt = i_op2[SHW-1:0];

    always_comb begin
        alu_res = '0;
        if      (i_alu[A_ADD])  alu_res = i_op1 + i_op2;
        else if (i_alu[A_SUB])  alu_res = i_op1 - i_op2;
        else if (i_alu[A_SLT])  alu_res = XLEN'($signed(i_op1) < $signed(i_op2));
        else if (i_alu[A_SLTU]) alu_res = XLEN'(i_op1 < i_op2);
        else if (i_alu[A_XOR])  alu_res = i_op1 ^ i_op2;
        else if (i_alu[A_OR])   alu_res = i_op1 | i_op2;
        else if (i_alu[A_AND])  alu_res = i_op1 & i_op2;
        else if (i_alu[A_SLL])  alu_res = i_op1 << shamt;
        else if (i_alu[A_SRL])  alu_res = i_op1 >> shamt;
        else if (i_alu[A_SRA])  alu_res = $signed(i_op1) >>> shamt;
        else if (i_alu[A_EQ])   alu_res = XLEN'(i_op1 == i_op2);
        else if (i_alu[A_NEQ])  alu_res = XLEN'(i_op1 != i_op2);
        else if (i_alu[A_GE])   alu_res = XLEN'($signed(i_op1) >= $signed(i_op2));
        else if (i_alu[A_GEU])  alu_res = XLEN'(i_op1 >= i_op2);
    end

    // One signed (XLEN+1)x(XLEN+1) multiply covers all four variants; the extra bit selects signedness.
    logic                     mul_s1, mul_s2;
    logic signed [XLEN:0]     mul_a, mul_b;
    logic signed [2*XLEN-1:0] mul_p;
    logic [XLEN-1:0]          mul_res, mul_q;
    assign mul_s1  = (i_funct3[1:0] == 2'd1) || (i_funct3[1:0] == 2'd2);
    assign mul_s2  = (i_funct3[1:0] == 2'd1);
    assign mul_a   = {mul_s1 & i_op1[XLEN-1], i_op1};
    assign mul_b   = {mul_s2 & i_op2[XLEN-1], i_op2};
    assign mul_p   = (2*XLEN)'(mul_a) * (2*XLEN)'(mul_b);
    assign mul_res = (i_funct3[1:0] == 2'd0) ? mul_p[XLEN-1:0] : mul_p[2*XLEN-1:XLEN];

    logic            div_signed, div_is_rem, div_zero, div_ovf, op1_neg, op2_neg;
    logic [XLEN-1:0] op1_mag, op2_mag, div_spec;
    assign div_signed = ~i_funct3[0];
    assign div_is_rem = i_funct3[1];
    assign div_zero   = (i_op2 == '0);
    assign div_ovf    = div_signed && (i_op1 == SMIN) && (&i_op2);
    assign op1_neg    = div_signed & i_op1[XLEN-1];
    assign op2_neg    = div_signed & i_op2[XLEN-1];
    assign op1_mag    = op1_neg ? -i_op1 : i_op1;
    assign op2_mag    = op2_neg ? -i_op2 : i_op2;
    assign div_spec   = div_zero ? (div_is_rem ? i_op1 : '1) : (div_is_rem ? '0 : i_op1);

    logic [XLEN-1:0] div_rem, div_quo, div_dsr, fix_res;
    logic [CW-1:0]   div_cnt;
    logic            neg_q, neg_r, rem_sel;
    logic [XLEN:0]   rem_sh, diff;
    assign rem_sh  = {div_rem, div_quo[XLEN-1]};
    assign diff    = rem_sh - {1'b0, div_dsr};
    assign fix_res = rem_sel ? (neg_r ? -div_rem : div_rem) : (neg_q ? -div_quo : div_quo);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            o_valid  <= 1'b0;
            o_result <= '0;
            mul_q    <= '0;
            div_rem  <= '0;
            div_quo  <= '0;
            div_dsr  <= '0;
            div_cnt  <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            rem_sel  <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (i_flush) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: if (i_valid) begin
                        if (!i_mdu_en) begin
                            o_result <= alu_res;
                            o_valid  <= 1'b1;
                        end else if (!i_funct3[2]) begin
                            if (MUL_LATENCY == 1) begin
                                o_result <= mul_res;
                                o_valid  <= 1'b1;
                            end else begin
                                mul_q <= mul_res;
                                state <= MUL2;
                            end
                        end else if (div_zero || div_ovf) begin
                            o_result <= div_spec;
                            o_valid  <= 1'b1;
                        end else begin
                            div_quo <= op1_mag;
                            div_rem <= '0;
                            div_dsr <= op2_mag;
                            div_cnt <= CW'(XLEN);
                            neg_q   <= op1_neg ^ op2_neg;
                            neg_r   <= op1_neg;
                            rem_sel <= div_is_rem;
                            state   <= DIV;
                        end
                    end
                    MUL2: begin
                        o_result <= mul_q;
                        o_valid  <= 1'b1;
                        state    <= IDLE;
                    end
                    DIV: begin
                        // Restoring step: keep the trial difference only when it did not borrow.
                        if (!diff[XLEN]) begin
                            div_rem <= diff[XLEN-1:0];
                            div_quo <= {div_quo[XLEN-2:0], 1'b1};
                        end else begin
                            div_rem <= rem_sh[XLEN-1:0];
                            div_quo <= {div_quo[XLEN-2:0], 1'b0};
                        end
                        div_cnt <= div_cnt - CW'(1);
                        if (div_cnt == CW'(1)) state <= FIX;
                    end
                    FIX: begin
                        o_result <= fix_res;
                        o_valid  <= 1'b1;
                        state    <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule
